// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_pkg
// Description : Shared encodings for the iterative multiply/divide unit:
//               operation codes, FSM state codes and a signedness helper.
// Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    // Operation codes presented on md_unit.op (6 and 7 are reserved)
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // FSM state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    // True for the two's-complement flavours of multiply and divide
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : md_sign_fix
// Description : Combinational sign helpers for md_unit. On the operand side
//               it extracts sign flags and magnitudes (signed ops only); on
//               the result side it conditionally negates product, quotient
//               and remainder.
// Ports       : a_i, b_i, signed_i        -> sign_a_o, sign_b_o,
//                                            mag_a_o, mag_b_o
//               prod_i, neg_prod_i         -> prod_o
//               quo_i, neg_quo_i           -> quo_o
//               rem_i, neg_rem_i           -> rem_o
// Revision    : 1.0 - initial release
// ============================================================================
module md_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    output logic               sign_a_o,
    output logic               sign_b_o,
    output logic [WIDTH-1:0]   mag_a_o,
    output logic [WIDTH-1:0]   mag_b_o,
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic               neg_prod_i,
    output logic [2*WIDTH-1:0] prod_o,
    input  logic [WIDTH-1:0]   quo_i,
    input  logic               neg_quo_i,
    output logic [WIDTH-1:0]   quo_o,
    input  logic [WIDTH-1:0]   rem_i,
    input  logic               neg_rem_i,
    output logic [WIDTH-1:0]   rem_o
);

    // Sign flags are already qualified by signedness, so downstream logic
    // never needs to look at the op again. The magnitude of the most-negative
    // value wraps to itself, which is exactly 2^(WIDTH-1) read as unsigned.
    assign sign_a_o = signed_i & a_i[WIDTH-1];
    assign sign_b_o = signed_i & b_i[WIDTH-1];
    assign mag_a_o  = sign_a_o ? -a_i : a_i;
    assign mag_b_o  = sign_b_o ? -b_i : b_i;

    assign prod_o   = neg_prod_i ? -prod_i : prod_i;
    assign quo_o    = neg_quo_i  ? -quo_i  : quo_i;
    assign rem_o    = neg_rem_i  ? -rem_i  : rem_i;

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Iterative multiply/divide unit with HI/LO result registers.
//               MULT/MULTU use one shift-add step per cycle, DIV/DIVU one
//               restoring step per cycle, followed by a FIX cycle that
//               applies signs and writes HI/LO. MTHI/MTLO write in one cycle.
// Ports       : clk, reset (async, active-low)
//               start, op, a, b  - request (sampled only while idle)
//               cancel           - abort in-flight operation, no HI/LO write
//               busy             - operation in flight (stall the pipeline)
//               done             - one-cycle pulse after HI/LO written
//               hi, lo           - result registers
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]         state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               sa_q,     sa_d;
    logic               sb_q,     sb_d;
    logic               is_div_q, is_div_d;
    logic               div0_q,   div0_d;
    logic [WIDTH-1:0]   opnd_q,   opnd_d;   // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] prod_q,   prod_d;   // product; multiplier in low half
    logic [WIDTH-1:0]   rem_q,    rem_d;
    logic [WIDTH-1:0]   quo_q,    quo_d;    // dividend shifts out, quotient in
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;
    logic               done_q,   done_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .a_i        (a),
        .b_i        (b),
        .signed_i   (op_is_signed(op)),
        .sign_a_o   (sign_a),
        .sign_b_o   (sign_b),
        .mag_a_o    (mag_a),
        .mag_b_o    (mag_b),
        .prod_i     (prod_q),
        .neg_prod_i (sa_q ^ sb_q),
        .prod_o     (prod_fix),
        .quo_i      (quo_q),
        .neg_quo_i  (sa_q ^ sb_q),
        .quo_o      (quo_fix),
        .rem_i      (rem_q),
        .neg_rem_i  (sa_q),
        .rem_o      (rem_fix)
    );

    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole product right, carry
    // included.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                    + (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

    // Restoring step on a WIDTH+1-bit working remainder; the extra bit of
    // the difference is the borrow deciding the quotient bit.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] div_diff;
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_diff  = {1'b0, rem_shift} - {2'b00, opnd_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        OP_MULT, OP_MULTU: begin
                            state_d  = ST_MUL;
                            cnt_d    = CNT_W'(WIDTH);
                            sa_d     = sign_a;
                            sb_d     = sign_b;
                            is_div_d = 1'b0;
                            div0_d   = 1'b0;
                            opnd_d   = mag_a;
                            prod_d   = {{WIDTH{1'b0}}, mag_b};
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = ST_DIV;
                            cnt_d    = CNT_W'(WIDTH);
                            sa_d     = sign_a;
                            sb_d     = sign_b;
                            is_div_d = 1'b1;
                            div0_d   = (b == '0);
                            opnd_d   = mag_b;
                            rem_d    = '0;
                            quo_d    = mag_a;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_DIV: begin
                if (!div_diff[WIDTH+1]) begin
                    rem_d = div_diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            default: begin // ST_FIX
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // Divide by zero leaves the remainder equal to the
                    // dividend naturally; only the quotient needs forcing.
                    hi_d = rem_fix;
                    lo_d = div0_q ? {WIDTH{1'b1}} : quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
        endcase

        // Abort overrides everything, including the FIX write.
        if (cancel && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            opnd_q   <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers, sitting in EX beside the combinational ALU.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles using shift-add multiplication and restoring division; handles MTHI/MTLO in a single cycle.
- Provides busy/done status for pipeline stall control, and a cancel input so interrupts and exceptions can abort an operation in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width; even, at least 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on a rising edge when busy=0.
- op  in  3  operation code (see package).
- a  in  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO source.
- b  in  WIDTH  operand B: multiplier or divisor.
- cancel  in  1  aborts the operation in flight; HI/LO stay unchanged.
- busy  out  1  high while an iterative operation is in flight.
- done  out  1  one-cycle pulse when HI/LO have just been written by MULT/DIV.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, any time, including mid-operation): state=IDLE; busy=0, done=0, hi=0, lo=0; counter and working registers cleared.
- States: IDLE, MUL, DIV, FIX.
- IDLE with start=1:
  - MTHI: hi<=a at that edge; no busy.
  - MTLO: lo<=a at that edge; no busy.
  - MULT/MULTU: go to MUL.
  - DIV/DIVU: go to DIV.
  - Undefined op: ignored, no state change.
- On entry to MUL/DIV:
  - Latch the signedness of the op and sign(a), sign(b).
  - Store magnitudes |a| and |b|, or raw values for the unsigned ops.
  - Counter=WIDTH.
- MUL: one shift-add step per cycle on a 2*WIDTH-bit product register; counter decrements; at counter==1 go to FIX.
- DIV: one restoring step per cycle (shift remainder:quotient left, trial subtract divisor, set quotient bit if non-negative); at counter==1 go to FIX.
- FIX:
  - Signed MULT: negate the 2*WIDTH product if sign(a)^sign(b).
  - Signed DIV: negate the quotient if sign(a)^sign(b); negate the remainder if sign(a).
  - Write hi/lo at the FIX edge, then go to IDLE.
  - MUL result: hi=product[2W-1:W], lo=product[W-1:0].
  - DIV result: lo=quotient, hi=remainder.
- Timing for a start sampled at edge k:
  - busy=1 from cycle k+1 through k+WIDTH+1 (WIDTH+1 cycles: WIDTH iterations plus FIX).
  - In cycle k+WIDTH+2: busy=0, done=1, hi/lo show the new values.
  - A new start is accepted in the done cycle.
- busy is registered and derived from state (state!=IDLE). done is registered: 1 only in the cycle after FIX.
- start while busy=1: ignored, including MTHI/MTLO. Pipeline stall logic guarantees issue only when busy=0.
- cancel=1 while busy: go to IDLE at the next edge; hi/lo not written; done stays 0.
  - cancel in the FIX cycle also wins: no write.
  - cancel with start in IDLE: start is ignored.
- Divide by zero (b==0), both signed and unsigned: lo=all-ones, hi=a (unmodified dividend); full latency still applies, no exception.
- Signed DIV of most-negative by -1: lo=most-negative, hi=0 (falls out of the magnitude algorithm; no trap).
- Arithmetic: the magnitude of the most-negative value is represented as unsigned 2^(WIDTH-1). The remainder working register is WIDTH+1 bits, so the trial subtract never loses its borrow.
- hi/lo hold their values in every cycle not listed above.

Decomposition:
- Package md_pkg:
  - op encodings: OP_MULT=3'd0, OP_MULTU=3'd1, OP_DIV=3'd2, OP_DIVU=3'd3, OP_MTHI=3'd4, OP_MTLO=3'd5; 6 and 7 reserved.
  - state encodings: IDLE, MUL, DIV, FIX.
- One natural sub-module, md_sign_fix: combinational magnitude/negate helpers used at entry and in FIX.
- The datapath and FSM stay in md_unit.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFD (-3), b=7 -> busy for 33 cycles, then done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; next start issued in the done cycle is accepted.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x00001234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234.
- MTHI a=0xA5A5A5A5 then start DIVU; cancel at iteration 10 -> busy drops the next cycle, done never pulses, hi=0xA5A5A5A5 unchanged. Repeat with reset=0 mid-MULT -> hi=lo=0, busy=0 immediately.
